// File: rtl/clk_en_meter_if.sv
// Signal bundle between a clock-enable rate meter and its user: control in, results out.
interface clk_en_meter_if #(
    parameter int INPUT_WIDTH = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   en_i;
    logic                   start_i;
    logic                   cont_i;
    logic                   busy_o;
    logic                   valid_o;
    logic [COUNT_WIDTH-1:0] count_o;
    logic [INPUT_WIDTH-1:0] freq_o;
    logic                   overflow_o;
    logic                   stable_o;

    modport master (
        output en_i, start_i, cont_i,
        input  busy_o, valid_o, count_o, freq_o, overflow_o, stable_o
    );

    modport slave (
        input  en_i, start_i, cont_i,
        output busy_o, valid_o, count_o, freq_o, overflow_o, stable_o
    );
endinterface

// File: rtl/clk_en_meter.sv
// Counts en_i pulses over a fixed gate window of INPUT_FREQ << SCALE_LOG2 cycles and
// reports the raw count plus the rate in the enable generator's frequency units.
module clk_en_meter #(
    parameter int INPUT_FREQ  = 125,
    parameter int INPUT_WIDTH = 8,
    parameter int SCALE_LOG2  = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int TOL         = 1
) (
    input  logic           clk,
    input  logic           rst_i,
    clk_en_meter_if.slave  bus
);
    localparam int WINDOW    = INPUT_FREQ << SCALE_LOG2;
    localparam int WIN_WIDTH = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_WIDTH-1:0]   WIN_LAST  = WIN_WIDTH'(WINDOW - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] TOL_C     = COUNT_WIDTH'(TOL);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic [INPUT_WIDTH-1:0] scale_freq(input logic [COUNT_WIDTH-1:0] c);
        logic [COUNT_WIDTH-1:0] shifted;
        shifted = c >> SCALE_LOG2;
        if ((shifted >> INPUT_WIDTH) != {COUNT_WIDTH{1'b0}}) begin
            return {INPUT_WIDTH{1'b1}};
        end else begin
            return shifted[INPUT_WIDTH-1:0];
        end
    endfunction

    state_t                 state_r;
    logic                   busy_r;
    logic                   valid_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [INPUT_WIDTH-1:0] freq_r;
    logic                   overflow_r;
    logic                   stable_r;
    logic [COUNT_WIDTH-1:0] pulse_r;
    logic                   sat_r;
    logic [WIN_WIDTH-1:0]   win_r;
    logic [COUNT_WIDTH-1:0] prev_r;
    logic                   prev_valid_r;

    logic [COUNT_WIDTH-1:0] pulse_next_s;
    logic                   sat_next_s;
    logic [COUNT_WIDTH-1:0] diff_s;
    logic                   stable_next_s;

    // Pulse count including the current sample, plus stability against the previous result.
    always_comb begin
        pulse_next_s = pulse_r;
        sat_next_s   = sat_r;
        if (bus.en_i) begin
            if (pulse_r == COUNT_MAX) begin
                sat_next_s = 1'b1;
            end else begin
                pulse_next_s = pulse_r + 1'b1;
            end
        end else begin
            pulse_next_s = pulse_r;
        end
        if (pulse_next_s >= prev_r) begin
            diff_s = pulse_next_s - prev_r;
        end else begin
            diff_s = prev_r - pulse_next_s;
        end
        stable_next_s = prev_valid_r && (diff_s <= TOL_C);
    end

    // Window sequencing and result registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
            count_r      <= {COUNT_WIDTH{1'b0}};
            freq_r       <= {INPUT_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
            stable_r     <= 1'b0;
            pulse_r      <= {COUNT_WIDTH{1'b0}};
            sat_r        <= 1'b0;
            win_r        <= {WIN_WIDTH{1'b0}};
            prev_r       <= {COUNT_WIDTH{1'b0}};
            prev_valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_i || bus.cont_i) begin
                        state_r      <= MEASURE;
                        busy_r       <= 1'b1;
                        pulse_r      <= {COUNT_WIDTH{1'b0}};
                        sat_r        <= 1'b0;
                        win_r        <= {WIN_WIDTH{1'b0}};
                        stable_r     <= 1'b0;
                        prev_valid_r <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (win_r == WIN_LAST) begin
                        count_r      <= pulse_next_s;
                        freq_r       <= scale_freq(pulse_next_s);
                        overflow_r   <= sat_next_s;
                        valid_r      <= 1'b1;
                        stable_r     <= stable_next_s;
                        prev_r       <= pulse_next_s;
                        prev_valid_r <= 1'b1;
                        // Counters reload on the same edge so continuous mode loses no sample.
                        pulse_r      <= {COUNT_WIDTH{1'b0}};
                        sat_r        <= 1'b0;
                        win_r        <= {WIN_WIDTH{1'b0}};
                        if (!bus.cont_i) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        pulse_r <= pulse_next_s;
                        sat_r   <= sat_next_s;
                        win_r   <= win_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.valid_o    = valid_r;
    assign bus.count_o    = count_r;
    assign bus.freq_o     = freq_r;
    assign bus.overflow_o = overflow_r;
    assign bus.stable_o   = stable_r;
endmodule
